uart_word_packer: RTL and testbench

//   Assembles bytes received by the UART link into 32-bit words for the FPGA

---
 rtl/uart_word_packer_if.sv | 22 ++
 rtl/uart_word_packer.sv | 115 +++++++++++
 tb/tb_uart_word_packer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_word_packer_if.sv
// Byte-in / word-out bundle between the UART receiver, the packer and the compute block.
// The packer side uses the master modport; stimulus or consumer logic uses the slave modport.
interface uart_word_packer_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic        overrun;
    logic        frame_err;
    logic [1:0]  byte_cnt;

    modport master (
        input  rx_data, rx_valid, word_ready,
        output word_data, word_valid, overrun, frame_err, byte_cnt
    );

    modport slave (
        output rx_data, rx_valid, word_ready,
        input  word_data, word_valid, overrun, frame_err, byte_cnt
    );
endinterface

// File: rtl/uart_word_packer.sv
// Packs UART bytes into 32-bit words behind a one-entry valid/ready slot.
// Stale partial words are dropped after an inter-byte idle timeout.
module uart_word_packer #(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter bit BIG_ENDIAN     = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    uart_word_packer_if.master bus
);
    localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
    localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    logic [0:0]    state_reg, state_next;
    logic [1:0]    cnt_reg, cnt_next;
    logic [31:0]   asm_reg, asm_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [31:0]   word_reg, word_next;
    logic          valid_reg, valid_next;
    logic          overrun_reg, overrun_next;
    logic          frame_err_reg, frame_err_next;
    logic [31:0]   full_word;
    logic          complete, transfer, timeout;

    // full_word is the assembly register with the incoming byte dropped into its lane.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] SLOT = BIG_ENDIAN ? 2'(3 - gi) : 2'(gi);
            assign full_word[8*gi +: 8] = (cnt_reg == SLOT) ? bus.rx_data : asm_reg[8*gi +: 8];
        end
    endgenerate

    assign complete = bus.rx_valid && (state_reg == ST_FILL) && (cnt_reg == 2'd3);
    assign transfer = valid_reg && bus.word_ready;
    assign timeout  = (TIMEOUT_CYCLES > 0) && (state_reg == ST_FILL) && !bus.rx_valid
                      && (timer_reg == TIMER_LAST);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        asm_next       = asm_reg;
        timer_next     = timer_reg;
        word_next      = word_reg;
        valid_next     = valid_reg;
        overrun_next   = 1'b0;
        frame_err_next = 1'b0;

        if (bus.rx_valid) begin
            if (complete) begin
                state_next = ST_IDLE;
                cnt_next   = 2'd0;
                asm_next   = '0;
            end else begin
                state_next = ST_FILL;
                cnt_next   = cnt_reg + 2'd1;
                asm_next   = full_word;
            end
        end else if (timeout) begin
            state_next     = ST_IDLE;
            cnt_next       = 2'd0;
            asm_next       = '0;
            frame_err_next = 1'b1;
        end

        if ((TIMEOUT_CYCLES == 0) || bus.rx_valid || (state_reg == ST_IDLE) || timeout)
            timer_next = '0;
        else if (timer_reg != TIMER_MAX)
            timer_next = timer_reg + 1'b1;

        // A completing word may only land in an empty slot or one emptying this edge.
        if (complete && (!valid_reg || transfer)) begin
            word_next  = full_word;
            valid_next = 1'b1;
        end else begin
            if (transfer)
                valid_next = 1'b0;
            if (complete)
                overrun_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 2'd0;
            asm_reg       <= '0;
            timer_reg     <= '0;
            word_reg      <= '0;
            valid_reg     <= 1'b0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            asm_reg       <= asm_next;
            timer_reg     <= timer_next;
            word_reg      <= word_next;
            valid_reg     <= valid_next;
            overrun_reg   <= overrun_next;
            frame_err_reg <= frame_err_next;
        end
    end

    assign bus.word_data  = word_reg;
    assign bus.word_valid = valid_reg;
    assign bus.overrun    = overrun_reg;
    assign bus.frame_err  = frame_err_reg;
    assign bus.byte_cnt   = cnt_reg;
endmodule

// File: tb/tb_uart_word_packer.sv
// Directed bench: a little-endian packer with a 16-cycle timeout and a big-endian
// packer with the timeout disabled share one byte stream.
module tb_uart_word_packer;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       word_ready;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_word_packer_if if_le();
    uart_word_packer_if if_be();

    assign if_le.rx_data    = rx_data;
    assign if_le.rx_valid   = rx_valid;
    assign if_le.word_ready = word_ready;
    assign if_be.rx_data    = rx_data;
    assign if_be.rx_valid   = rx_valid;
    assign if_be.word_ready = word_ready;

    uart_word_packer #(.TIMEOUT_CYCLES(16), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .reset(reset), .bus(if_le.master)
    );
    uart_word_packer #(.TIMEOUT_CYCLES(0), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .reset(reset), .bus(if_be.master)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; word_ready = 1'b0;
        step();
        step();
        checks++;
        if ({if_le.word_data, if_le.word_valid, if_le.overrun, if_le.frame_err, if_le.byte_cnt} !== 37'd0) begin
            errors++; $display("FAIL reset_le: got data=%h valid=%b cnt=%0d, expected all zero",
                               if_le.word_data, if_le.word_valid, if_le.byte_cnt);
        end else $display("ok reset_le");
        checks++;
        if ({if_be.word_data, if_be.word_valid, if_be.overrun, if_be.frame_err, if_be.byte_cnt} !== 37'd0) begin
            errors++; $display("FAIL reset_be: got data=%h valid=%b cnt=%0d, expected all zero",
                               if_be.word_data, if_be.word_valid, if_be.byte_cnt);
        end else $display("ok reset_be");
        reset = 1'b1;
    endtask

    task automatic test_little_endian();
        word_ready = 1'b1;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        checks++;
        if (if_le.word_valid !== 1'b1 || if_le.word_data !== 32'h44332211) begin
            errors++; $display("FAIL le_word: got valid=%b data=%h, expected 1 44332211",
                               if_le.word_valid, if_le.word_data);
        end else $display("ok le_word data=%h", if_le.word_data);
        step();
        checks++;
        if (if_le.word_valid !== 1'b0) begin
            errors++; $display("FAIL le_valid_drop: got %b expected 0", if_le.word_valid);
        end else $display("ok le_valid_drop");
    endtask

    task automatic test_big_endian();
        do_reset();
        word_ready = 1'b1;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        checks++;
        if (if_be.word_valid !== 1'b1 || if_be.word_data !== 32'h11223344) begin
            errors++; $display("FAIL be_word: got valid=%b data=%h, expected 1 11223344",
                               if_be.word_valid, if_be.word_data);
        end else $display("ok be_word data=%h", if_be.word_data);
        step();
        checks++;
        if (if_be.word_valid !== 1'b0) begin
            errors++; $display("FAIL be_valid_drop: got %b expected 0", if_be.word_valid);
        end else $display("ok be_valid_drop");
    endtask

    task automatic test_overrun();
        logic [7:0] bytes [8];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        word_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_byte(bytes[i]);
            if (i >= 4 && i < 7) begin
                checks++;
                if (if_le.overrun !== 1'b0 || if_le.word_data !== 32'h44332211 || if_le.word_valid !== 1'b1) begin
                    errors++; $display("FAIL ovr_hold_%0d: got ovr=%b valid=%b data=%h, expected 0 1 44332211",
                                       i, if_le.overrun, if_le.word_valid, if_le.word_data);
                end else $display("ok ovr_hold_%0d", i);
            end
        end
        checks++;
        if (if_le.overrun !== 1'b1 || if_le.byte_cnt !== 2'd0 || if_le.word_data !== 32'h44332211) begin
            errors++; $display("FAIL ovr_pulse: got ovr=%b cnt=%0d data=%h, expected 1 0 44332211",
                               if_le.overrun, if_le.byte_cnt, if_le.word_data);
        end else $display("ok ovr_pulse");
        step();
        checks++;
        if (if_le.overrun !== 1'b0) begin
            errors++; $display("FAIL ovr_one_cycle: got %b expected 0", if_le.overrun);
        end else $display("ok ovr_one_cycle");
        word_ready = 1'b1;
        step();
        step();
        checks++;
        if (if_le.word_valid !== 1'b0) begin
            errors++; $display("FAIL ovr_drain: got valid=%b expected 0", if_le.word_valid);
        end else $display("ok ovr_drain");
    endtask

    task automatic test_back_to_back();
        word_ready = 1'b0;
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
        send_byte(8'hB1); send_byte(8'hB2); send_byte(8'hB3);
        word_ready = 1'b1;
        send_byte(8'hB4);
        checks++;
        if (if_le.word_valid !== 1'b1 || if_le.word_data !== 32'hB4B3B2B1 || if_le.overrun !== 1'b0) begin
            errors++; $display("FAIL b2b_refill: got valid=%b data=%h ovr=%b, expected 1 b4b3b2b1 0",
                               if_le.word_valid, if_le.word_data, if_le.overrun);
        end else $display("ok b2b_refill data=%h", if_le.word_data);
        step();
        checks++;
        if (if_le.word_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drain: got %b expected 0", if_le.word_valid);
        end else $display("ok b2b_drain");
    endtask

    task automatic test_timeout();
        do_reset();
        word_ready = 1'b1;
        send_byte(8'hC1); send_byte(8'hC2);
        for (int i = 0; i < 15; i++) begin
            step();
            checks++;
            if (if_le.frame_err !== 1'b0 || if_le.byte_cnt !== 2'd2) begin
                errors++; $display("FAIL to_wait_%0d: got ferr=%b cnt=%0d, expected 0 2",
                                   i, if_le.frame_err, if_le.byte_cnt);
            end
        end
        step();
        checks++;
        if (if_le.frame_err !== 1'b1 || if_le.byte_cnt !== 2'd0) begin
            errors++; $display("FAIL to_fire: got ferr=%b cnt=%0d, expected 1 0", if_le.frame_err, if_le.byte_cnt);
        end else $display("ok to_fire");
        checks++;
        if (if_be.frame_err !== 1'b0 || if_be.byte_cnt !== 2'd2) begin
            errors++; $display("FAIL to_disabled: got ferr=%b cnt=%0d, expected 0 2", if_be.frame_err, if_be.byte_cnt);
        end else $display("ok to_disabled");
        step();
        checks++;
        if (if_le.frame_err !== 1'b0) begin
            errors++; $display("FAIL to_one_cycle: got %b expected 0", if_le.frame_err);
        end else $display("ok to_one_cycle");
        send_byte(8'hD1); send_byte(8'hD2); send_byte(8'hD3); send_byte(8'hD4);
        checks++;
        if (if_le.word_valid !== 1'b1 || if_le.word_data !== 32'hD4D3D2D1) begin
            errors++; $display("FAIL to_clean_word: got valid=%b data=%h, expected 1 d4d3d2d1",
                               if_le.word_valid, if_le.word_data);
        end else $display("ok to_clean_word data=%h", if_le.word_data);
    endtask

    task automatic test_expiry();
        do_reset();
        word_ready = 1'b1;
        send_byte(8'hE1); send_byte(8'hE2);
        for (int i = 0; i < 15; i++) step();
        send_byte(8'hE3);
        checks++;
        if (if_le.frame_err !== 1'b0 || if_le.byte_cnt !== 2'd3) begin
            errors++; $display("FAIL expiry_byte: got ferr=%b cnt=%0d, expected 0 3", if_le.frame_err, if_le.byte_cnt);
        end else $display("ok expiry_byte");
        send_byte(8'hE4);
        checks++;
        if (if_le.word_valid !== 1'b1 || if_le.word_data !== 32'hE4E3E2E1) begin
            errors++; $display("FAIL expiry_word: got valid=%b data=%h, expected 1 e4e3e2e1",
                               if_le.word_valid, if_le.word_data);
        end else $display("ok expiry_word data=%h", if_le.word_data);
    endtask

    task automatic test_reset_midword();
        do_reset();
        word_ready = 1'b0;
        send_byte(8'hF1); send_byte(8'hF2); send_byte(8'hF3); send_byte(8'hF4);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        checks++;
        if (if_le.word_valid !== 1'b1 || if_le.byte_cnt !== 2'd3) begin
            errors++; $display("FAIL mid_setup: got valid=%b cnt=%0d, expected 1 3", if_le.word_valid, if_le.byte_cnt);
        end else $display("ok mid_setup");
        reset = 1'b0;
        #1;
        checks++;
        if ({if_le.word_data, if_le.word_valid, if_le.overrun, if_le.frame_err, if_le.byte_cnt} !== 37'd0) begin
            errors++; $display("FAIL mid_async_le: got data=%h valid=%b cnt=%0d, expected all zero",
                               if_le.word_data, if_le.word_valid, if_le.byte_cnt);
        end else $display("ok mid_async_le");
        checks++;
        if ({if_be.word_data, if_be.word_valid, if_be.overrun, if_be.frame_err, if_be.byte_cnt} !== 37'd0) begin
            errors++; $display("FAIL mid_async_be: got data=%h valid=%b cnt=%0d, expected all zero",
                               if_be.word_data, if_be.word_valid, if_be.byte_cnt);
        end else $display("ok mid_async_be");
        step();
        reset = 1'b1;
        word_ready = 1'b1;
        send_byte(8'h5A); send_byte(8'h6B); send_byte(8'h7C); send_byte(8'h8D);
        checks++;
        if (if_le.word_valid !== 1'b1 || if_le.word_data !== 32'h8D7C6B5A) begin
            errors++; $display("FAIL mid_after_le: got valid=%b data=%h, expected 1 8d7c6b5a",
                               if_le.word_valid, if_le.word_data);
        end else $display("ok mid_after_le data=%h", if_le.word_data);
        checks++;
        if (if_be.word_valid !== 1'b1 || if_be.word_data !== 32'h5A6B7C8D) begin
            errors++; $display("FAIL mid_after_be: got valid=%b data=%h, expected 1 5a6b7c8d",
                               if_be.word_valid, if_be.word_data);
        end else $display("ok mid_after_be data=%h", if_be.word_data);
    endtask

    initial begin
        test_reset();
        test_little_endian();
        test_big_endian();
        test_overrun();
        test_back_to_back();
        test_timeout();
        test_expiry();
        test_reset_midword();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
